lcd8080_write_engine: RTL and testbench
=======================================

// Module: lcd8080_write_engine
// PURPOSE
//  Byte-level 8080-parallel write engine driving the VMA412 (ILI9341) LCD bus.
//  Runs the panel hardware-reset sequence on RESX, then drains a small FIFO of {dc,byte} entries.
//  Each entry becomes one timed CSX/DCX/WRX write cycle.
//  Sits directly below the vma412 command/pixel sequencer, which pushes commands and data here.
// PARAMETERS
//  FIFO_DEPTH     4        entries in input FIFO; power of 2, >=2
//  SETUP_CYC      1        cycles CSX low + DCX/DB valid before WRX falls (>=1)
//  WR_LOW_CYC     2        cycles WRX held low (>=1)
//  WR_HIGH_CYC    2        cycles WRX held high after rising edge, DB held (>=1)
//  RESX_LOW_CYC   500      cycles RESX held low after reset (10 us @ 50 MHz)
//  RESX_WAIT_CYC  6000000  cycles after RESX rises before first write (120 ms)
// PORTS
//  CLOCK_50   in   1  system clock, 50 MHz
//  reset      in   1  asynchronous, active-high reset
//  in_valid   in   1  upstream has an entry
//  in_ready   out  1  FIFO can accept; transfer when in_valid & in_ready
//  in_dc      in   1  0 = command byte, 1 = parameter/pixel data
//  in_data    in   8  byte to write
//  init_done  out  1  RESX sequence complete; sticky until reset
//  busy       out  1  init running, FIFO non-empty, or bus cycle in progress
//  csx        out  1  chip select, active low
//  resx       out  1  panel reset, active low
//  dcx        out  1  data/command select
//  wrx        out  1  write strobe, panel latches DB on rising edge
//  rdx        out  1  read strobe; tied 1 (no reads)
//  db         out  8  parallel data bus
// BEHAVIOUR
//  Reset (async): csx=1 resx=0 dcx=1 wrx=1 rdx=1 db=0 init_done=0 busy=1; FIFO flushed; state RST_LOW.
//  All outputs registered. One down-counter, width $clog2(max param)+1, shared by states.
//  FSM:
//   RST_LOW  : resx=0 for RESX_LOW_CYC cycles -> RST_WAIT.
//   RST_WAIT : resx=1 for RESX_WAIT_CYC cycles -> IDLE; init_done=1 on entry to IDLE.
//   IDLE     : FIFO non-empty -> pop head, load dcx/db, csx=0 -> SETUP; else hold, csx=1.
//   SETUP    : SETUP_CYC cycles, wrx=1 -> WR_LOW.
//   WR_LOW   : wrx=0 for WR_LOW_CYC cycles -> WR_HIGH.
//   WR_HIGH  : wrx=1 for WR_HIGH_CYC cycles, dcx/db held -> HOLD.
//   HOLD     : csx=1 one cycle, dcx/db held -> IDLE.
//  Latency: entry accepted at edge N into empty FIFO while IDLE -> csx/db/dcx change at edge N+1.
//  Cycle length per byte = SETUP_CYC+WR_LOW_CYC+WR_HIGH_CYC+1 (+1 IDLE) clocks.
//  FIFO: in_ready = ~full (registered, from count); accepts entries during RST_LOW/RST_WAIT.
//   Push while full ignored (in_ready=0 there); simultaneous push+pop on non-full FIFO keeps count.
//   Pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
//  busy = ~init_done | count!=0 | state!=IDLE.
//  Reset mid-cycle: bus returns to idle values immediately, queued bytes discarded, RESX sequence restarts.
//  db/dcx hold last written value while idle; never change while csx=0 except at SETUP entry.
// CONFIGURATION
//  LCD8080_BURST_EN defined: at end of WR_HIGH, if FIFO non-empty, pop next entry and go straight to
//   SETUP with csx kept 0; HOLD and IDLE skipped; per-byte cycle = SETUP+WR_LOW+WR_HIGH.
//   csx rises (HOLD) only when FIFO empty at end of WR_HIGH.
//  Undefined: every byte gets own csx low pulse via HOLD and IDLE as above.
// TESTING (RESX_LOW_CYC=4, RESX_WAIT_CYC=10, defaults otherwise)
//  Reset pulse -> resx=0 4 cycles, then 1; init_done rises 10 cycles later; csx/wrx stay 1 throughout.
//  Push {dc=0,0x2C} after init_done -> csx low 1 cycle later; dcx=0 db=0x2C; wrx low exactly 2 cycles; csx high after 5.
//  Push 4 entries during RST_WAIT -> all accepted, in_ready=0 at 4, 5th held; bytes emitted in order after init_done.
//  Back-to-back 0x11,0x22,0x33 (dc=1): without BURST_EN csx pulses high between bytes;
//   with LCD8080_BURST_EN csx stays low across all three, 3 wrx low pulses spaced 5 cycles.
//  Assert reset during WR_LOW of second byte -> wrx,csx=1 and resx=0 same cycle; FIFO empty; no further wrx pulses until re-init.
//  Check rdx=1 always; count never exceeds 4 under random push with random valid gaps.

Source files
------------

// File: rtl/lcd8080_write_engine_if.sv
// lcd8080_write_engine_if
// Bundles the upstream byte handshake, the status flags and the 8080-style
// LCD bus of the write engine. The engine connects through the slave modport;
// the upstream sequencer (or a bench) uses the master modport.
interface lcd8080_write_engine_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_dc;
    logic [7:0] in_data;
    logic       init_done;
    logic       busy;
    logic       csx;
    logic       resx;
    logic       dcx;
    logic       wrx;
    logic       rdx;
    logic [7:0] db;

    modport master (
        output in_valid, in_dc, in_data,
        input  in_ready, init_done, busy, csx, resx, dcx, wrx, rdx, db
    );

    modport slave (
        input  in_valid, in_dc, in_data,
        output in_ready, init_done, busy, csx, resx, dcx, wrx, rdx, db
    );
endinterface

// File: rtl/lcd8080_write_engine.sv
// lcd8080_write_engine
// Byte-level 8080-parallel write engine for the VMA412 (ILI9341) panel.
// After reset it runs the RESX hardware-reset sequence, then drains a small
// FIFO of {dc, byte} entries, turning each into one timed CSX/DCX/WRX write.
// Optional feature macro: LCD8080_BURST_EN -- when defined, consecutive
// queued bytes share a single CSX low window (no HOLD/IDLE between bytes).
module lcd8080_write_engine #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYC     = 1,
    parameter int WR_LOW_CYC    = 2,
    parameter int WR_HIGH_CYC   = 2,
    parameter int RESX_LOW_CYC  = 500,
    parameter int RESX_WAIT_CYC = 6000000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    lcd8080_write_engine_if.slave  bus
);

`ifdef LCD8080_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam int MAX_A   = (SETUP_CYC > WR_LOW_CYC) ? SETUP_CYC : WR_LOW_CYC;
    localparam int MAX_B   = (WR_HIGH_CYC > MAX_A) ? WR_HIGH_CYC : MAX_A;
    localparam int MAX_C   = (RESX_LOW_CYC > MAX_B) ? RESX_LOW_CYC : MAX_B;
    localparam int MAX_CYC = (RESX_WAIT_CYC > MAX_C) ? RESX_WAIT_CYC : MAX_C;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FC_W    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [FC_W-1:0] FULL_COUNT = FC_W'(FIFO_DEPTH);

    localparam logic [2:0] RST_LOW  = 3'd0;
    localparam logic [2:0] RST_WAIT = 3'd1;
    localparam logic [2:0] IDLE     = 3'd2;
    localparam logic [2:0] SETUP    = 3'd3;
    localparam logic [2:0] WR_LOW   = 3'd4;
    localparam logic [2:0] WR_HIGH  = 3'd5;
    localparam logic [2:0] HOLD     = 3'd6;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             csx_q;
    logic             resx_q;
    logic             dcx_q;
    logic             wrx_q;
    logic [7:0]       db_q;
    logic             init_done_q;

    logic [8:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [FC_W-1:0]  fifo_count;
    logic [8:0]       head;
    logic             in_ready;
    logic             push;
    logic             pop;

    assign in_ready = (fifo_count != FULL_COUNT);
    assign push     = bus.in_valid & in_ready;
    assign head     = fifo_mem[rd_ptr];

    // Pop the FIFO head whenever the FSM is about to start a new byte: from
    // IDLE, or straight out of WR_HIGH when bursting is enabled.
    always_comb begin
        pop = 1'b0;
        if (fifo_count != '0) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (BURST_EN && (state == WR_HIGH) && (cnt == '0)) begin
                pop = 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.in_dc, bus.in_data};
        end
    end

    // FIFO pointers and occupancy; reset flushes any queued bytes.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Panel reset sequence followed by the per-byte write-cycle FSM; one
    // shared down-counter times every state and all bus pins are registered.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= RST_LOW;
            cnt         <= CNT_W'(RESX_LOW_CYC - 1);
            csx_q       <= 1'b1;
            resx_q      <= 1'b0;
            dcx_q       <= 1'b1;
            wrx_q       <= 1'b1;
            db_q        <= 8'h00;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                RST_LOW: begin
                    if (cnt == '0) begin
                        resx_q <= 1'b1;
                        cnt    <= CNT_W'(RESX_WAIT_CYC - 1);
                        state  <= RST_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == '0) begin
                        init_done_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (pop) begin
                        dcx_q <= head[8];
                        db_q  <= head[7:0];
                        csx_q <= 1'b0;
                        cnt   <= CNT_W'(SETUP_CYC - 1);
                        state <= SETUP;
                    end else begin
                        csx_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        wrx_q <= 1'b0;
                        cnt   <= CNT_W'(WR_LOW_CYC - 1);
                        state <= WR_LOW;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_LOW: begin
                    if (cnt == '0) begin
                        wrx_q <= 1'b1;
                        cnt   <= CNT_W'(WR_HIGH_CYC - 1);
                        state <= WR_HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_HIGH: begin
                    if (cnt == '0) begin
                        if (pop) begin
                            dcx_q <= head[8];
                            db_q  <= head[7:0];
                            cnt   <= CNT_W'(SETUP_CYC - 1);
                            state <= SETUP;
                        end else begin
                            csx_q <= 1'b1;
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    csx_q <= 1'b1;
                    wrx_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.init_done = init_done_q;
    assign bus.busy      = ~init_done_q | (fifo_count != '0) | (state != IDLE);
    assign bus.csx       = csx_q;
    assign bus.resx      = resx_q;
    assign bus.dcx       = dcx_q;
    assign bus.wrx       = wrx_q;
    assign bus.rdx       = 1'b1;
    assign bus.db        = db_q;

endmodule

// File: tb/tb_lcd8080_write_engine.sv
// tb_lcd8080_write_engine
// Self-checking bench for lcd8080_write_engine with shortened RESX timing.
// A queue of accepted {dc,byte} entries is the reference: every WRX rising
// edge must present the oldest outstanding entry on DCX/DB. Bus timing is
// checked against cycle counts derived from the timing parameters.
// Honours LCD8080_BURST_EN the same way the design does.
module tb_lcd8080_write_engine;

    localparam int FIFO_DEPTH = 4;
    localparam int SETUP_CYC  = 1;
    localparam int WRL_CYC    = 2;
    localparam int WRH_CYC    = 2;
    localparam int RLOW_CYC   = 4;
    localparam int RWAIT_CYC  = 10;

`ifdef LCD8080_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int BYTE_SPACING = BURST ? (SETUP_CYC + WRL_CYC + WRH_CYC)
                                        : (SETUP_CYC + WRL_CYC + WRH_CYC + 2);
    localparam int CS_RISES_3   = BURST ? 1 : 3;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    lcd8080_write_engine_if bus ();

    lcd8080_write_engine #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .SETUP_CYC     (SETUP_CYC),
        .WR_LOW_CYC    (WRL_CYC),
        .WR_HIGH_CYC   (WRH_CYC),
        .RESX_LOW_CYC  (RLOW_CYC),
        .RESX_WAIT_CYC (RWAIT_CYC)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int         total = 0;
    int         bad   = 0;
    logic [8:0] exp_q [$];
    logic [8:0] mon_exp;
    logic       prev_wrx;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic applyStimulus(input logic dc, input logic [7:0] data,
                                 input int budget, output int used);
        logic rdy;
        bit   acc;
        acc  = 1'b0;
        used = 0;
        bus.in_valid = 1'b1;
        bus.in_dc    = dc;
        bus.in_data  = data;
        while (!acc && used < budget) begin
            rdy = bus.in_ready;
            tick();
            used++;
            if (rdy) begin
                acc = 1'b1;
                exp_q.push_back({dc, data});
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_busy", 32'(bus.busy), 32'd0);
        checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every completed write must match the oldest outstanding entry.
    always @(negedge CLOCK_50) begin
        if (reset) begin
            prev_wrx <= 1'b1;
        end else begin
            checkOutput("rdx_high", 32'(bus.rdx), 32'd1);
            if (!bus.wrx) begin
                checkOutput("wrx_inside_cs", 32'(bus.csx), 32'd0);
            end
            if (!prev_wrx && bus.wrx) begin
                checkOutput("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("wr_byte", 32'({bus.dcx, bus.db}), 32'(mon_exp));
                end
            end
            prev_wrx <= bus.wrx;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        int         m;
        int         used;
        int         k;
        int         nf;
        int         rises;
        int         fall [3];
        int         idx;
        int         cs_low;
        int         wr_low;
        int         first_cs;
        int         first_wr;
        int         wr_seen;
        bit         quiet;
        bit         held;
        bit         v;
        logic       rdy;
        logic       prev_c;
        logic       prev_w;
        logic [7:0] seq [3];
        logic [7:0] rd;

        bus.in_valid = 1'b0;
        bus.in_dc    = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b1;
        tick();
        tick();

        // Reset values of the bus and status flags.
        checkOutput("rst_bus", 32'({bus.csx, bus.resx, bus.dcx, bus.wrx, bus.rdx}), 32'b10111);
        checkOutput("rst_db", 32'(bus.db), 32'h00);
        checkOutput("rst_flags", 32'({bus.init_done, bus.busy, bus.in_ready}), 32'b011);

        // RESX low phase length.
        reset = 1'b0;
        n     = 0;
        quiet = 1'b1;
        while (!bus.resx && n < 50) begin
            tick();
            n++;
            if (!bus.csx || !bus.wrx) quiet = 1'b0;
        end
        checkOutput("resx_low_cycles", 32'(n), 32'(RLOW_CYC));

        // Fill the FIFO during RST_WAIT; the fifth entry must be held off.
        m = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'(i), 8'hA0 + 8'(i), 5, used);
            m += used;
            if (!bus.csx || !bus.wrx) quiet = 1'b0;
        end
        checkOutput("full_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("full_queue", 32'(exp_q.size()), 32'd4);
        held         = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_dc    = 1'b1;
        bus.in_data  = 8'h5E;
        while (!bus.init_done && m < 50) begin
            rdy = bus.in_ready;
            tick();
            m++;
            if (!bus.csx || !bus.wrx) quiet = 1'b0;
            if (rdy && held) begin
                held = 1'b0;
                exp_q.push_back({1'b1, 8'h5E});
                bus.in_valid = 1'b0;
            end
        end
        checkOutput("init_done_delay", 32'(m), 32'(RWAIT_CYC));
        checkOutput("fifth_held", 32'(held), 32'd1);
        checkOutput("init_quiet", 32'(quiet), 32'd1);
        if (held) applyStimulus(1'b1, 8'h5E, 20, used);
        waitIdle(300);

        // Single command byte: latency and strobe widths.
        bus.in_valid = 1'b1;
        bus.in_dc    = 1'b0;
        bus.in_data  = 8'h2C;
        rdy          = bus.in_ready;
        tick();
        if (rdy) exp_q.push_back({1'b0, 8'h2C});
        bus.in_valid = 1'b0;
        checkOutput("single_accept", 32'(rdy), 32'd1);
        checkOutput("single_pre_csx", 32'(bus.csx), 32'd1);
        cs_low   = 0;
        wr_low   = 0;
        first_cs = 0;
        first_wr = 0;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) checkOutput("single_dcx_db", 32'({bus.dcx, bus.db}), 32'h02C);
            if (!bus.csx) cs_low++;
            if (!bus.wrx) wr_low++;
            if (!bus.csx && first_cs == 0) first_cs = k;
            if (!bus.wrx && first_wr == 0) first_wr = k;
        end
        checkOutput("single_cs_latency", 32'(first_cs), 32'd1);
        checkOutput("single_wr_fall", 32'(first_wr), 32'(1 + SETUP_CYC));
        checkOutput("single_wr_low", 32'(wr_low), 32'(WRL_CYC));
        checkOutput("single_cs_low", 32'(cs_low), 32'(SETUP_CYC + WRL_CYC + WRH_CYC));
        waitIdle(100);

        // Back-to-back data bytes: strobe spacing and CSX behaviour.
        seq[0] = 8'h11;
        seq[1] = 8'h22;
        seq[2] = 8'h33;
        idx    = 0;
        nf     = 0;
        rises  = 0;
        prev_c = bus.csx;
        prev_w = bus.wrx;
        for (k = 1; k <= 40; k++) begin
            if (idx < 3) begin
                bus.in_valid = 1'b1;
                bus.in_dc    = 1'b1;
                bus.in_data  = seq[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            rdy = bus.in_ready;
            tick();
            if (idx < 3 && rdy) begin
                exp_q.push_back({1'b1, seq[idx]});
                idx++;
            end
            if (prev_w && !bus.wrx) begin
                if (nf < 3) fall[nf] = k;
                nf++;
            end
            if (!prev_c && bus.csx) rises++;
            prev_c = bus.csx;
            prev_w = bus.wrx;
        end
        bus.in_valid = 1'b0;
        checkOutput("b2b_pushed", 32'(idx), 32'd3);
        checkOutput("b2b_wr_pulses", 32'(nf), 32'd3);
        if (nf >= 3) begin
            checkOutput("b2b_spacing_1", 32'(fall[1] - fall[0]), 32'(BYTE_SPACING));
            checkOutput("b2b_spacing_2", 32'(fall[2] - fall[1]), 32'(BYTE_SPACING));
        end
        checkOutput("b2b_cs_rises", 32'(rises), 32'(CS_RISES_3));
        waitIdle(100);

        // Reset in the middle of the second byte's WR_LOW phase.
        for (int i = 0; i < 3; i++) seq[i] = 8'($urandom_range(0, 255));
        idx    = 0;
        nf     = 0;
        prev_w = bus.wrx;
        k      = 0;
        while (nf < 2 && k < 40) begin
            if (idx < 3) begin
                bus.in_valid = 1'b1;
                bus.in_dc    = 1'b1;
                bus.in_data  = seq[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            rdy = bus.in_ready;
            tick();
            k++;
            if (idx < 3 && rdy) begin
                exp_q.push_back({1'b1, seq[idx]});
                idx++;
            end
            if (prev_w && !bus.wrx) nf++;
            prev_w = bus.wrx;
        end
        bus.in_valid = 1'b0;
        checkOutput("midrst_reached", 32'(nf), 32'd2);
        reset = 1'b1;
        #1;
        exp_q.delete();
        checkOutput("midrst_bus", 32'({bus.csx, bus.resx, bus.wrx}), 32'b101);
        checkOutput("midrst_flags", 32'({bus.init_done, bus.busy, bus.in_ready}), 32'b011);
        tick();
        tick();
        reset   = 1'b0;
        n       = 0;
        wr_seen = 0;
        while (!bus.init_done && n < 100) begin
            tick();
            n++;
            if (!bus.wrx) wr_seen++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.wrx) wr_seen++;
        end
        checkOutput("reinit_delay", 32'(n), 32'(RLOW_CYC + RWAIT_CYC));
        checkOutput("reinit_no_wr", 32'(wr_seen), 32'd0);
        checkOutput("reinit_busy", 32'(bus.busy), 32'd0);

        // Random traffic with random valid gaps.
        for (int it = 0; it < 300; it++) begin
            v  = ($urandom_range(0, 3) != 0);
            rd = 8'($urandom_range(0, 255));
            bus.in_valid = v;
            bus.in_dc    = 1'($urandom_range(0, 1));
            bus.in_data  = rd;
            rdy = bus.in_ready;
            tick();
            if (v && rdy) begin
                exp_q.push_back({bus.in_dc, bus.in_data});
                checkOutput("rand_outstanding", 32'(exp_q.size() <= FIFO_DEPTH + 1), 32'd1);
            end
        end
        bus.in_valid = 1'b0;
        waitIdle(3000);
        checkOutput("final_idle_bus", 32'({bus.csx, bus.wrx, bus.in_ready}), 32'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
